// File: rtl/clk_1sec_div.sv
// clk_1sec_div: counter-based divider turning the board clock into a slow,
// near-50%-duty registered clock; odd divisors spend the extra cycle low.
module clk_1sec_div #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int OUT_FREQ_HZ = 1
) (
  input  logic clock,
  input  logic rst,
  output logic clk_out
);

  localparam int DIV    = CLK_FREQ_HZ / OUT_FREQ_HZ;
  localparam int HI_CYC = DIV / 2;
  localparam int LO_CYC = DIV - HI_CYC;
  localparam int CW     = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CW-1:0] LO_LAST = CW'(LO_CYC - 1);
  localparam logic [CW-1:0] HI_LAST = CW'(HI_CYC - 1);

  // A divisor below 2 cannot produce both a high and a low phase.
  if (DIV < 2) begin : g_bad_div
    $error("clk_1sec_div: DIV=%0d is illegal, must be at least 2", DIV);
  end

  logic [CW-1:0] r_cnt;
  logic          r_clkOut;
  logic          w_phaseEnd;

  always_comb begin
    w_phaseEnd = r_clkOut ? (r_cnt == HI_LAST) : (r_cnt == LO_LAST);
  end

  // Counter restarts at every phase boundary, so it never reaches 2^CW.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_clkOut <= 1'b0;
    end else if (w_phaseEnd) begin
      r_cnt    <= '0;
      r_clkOut <= ~r_clkOut;
    end else begin
      r_cnt    <= r_cnt + CW'(1);
    end
  end

  assign clk_out = r_clkOut;

endmodule

// File: tb/tb_clk_1sec_div.sv
// tb_clk_1sec_div: checks the divider at DIV=10, 7 and 2 (plus the default
// 100 MHz build for its reset/idle behaviour) against a phase-position model.
module tb_clk_1sec_div;

  logic clock;
  logic rst;
  logic o10, o7, o2, oDflt;

  int checkCnt = 0;
  int passCnt  = 0;
  int cur      = 0;

  typedef struct {
    int         edgeNum;
    logic [2:0] exp;
  } vec_t;

  vec_t       tbl[12];
  logic [2:0] sbQ[$];

  clk_1sec_div #(.CLK_FREQ_HZ(10), .OUT_FREQ_HZ(1)) u_div10 (
    .clock(clock), .rst(rst), .clk_out(o10));
  clk_1sec_div #(.CLK_FREQ_HZ(7), .OUT_FREQ_HZ(1)) u_div7 (
    .clock(clock), .rst(rst), .clk_out(o7));
  clk_1sec_div #(.CLK_FREQ_HZ(2), .OUT_FREQ_HZ(1)) u_div2 (
    .clock(clock), .rst(rst), .clk_out(o2));
  clk_1sec_div u_dflt (
    .clock(clock), .rst(rst), .clk_out(oDflt));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Output is high once the position within the period reaches the low length.
  function automatic logic modelOut(input int n, input int div);
    int lo;
    lo = div - div / 2;
    return ((n % div) >= lo);
  endfunction

  function automatic logic [2:0] modelAll(input int n);
    return {modelOut(n, 10), modelOut(n, 7), modelOut(n, 2)};
  endfunction

  task automatic checkOutput(input string name, input logic [2:0] act,
                             input logic [2:0] exp);
    checkCnt++;
    if (act === exp) passCnt++;
    else $display("[TB] FAIL %s: got %b, required %b", name, act, exp);
  endtask

  task automatic applyStimulus(input logic rstVal, input int cycles);
    rst = rstVal;
    repeat (cycles) @(negedge clock);
  endtask

  initial begin
    tbl[0]  = '{1,  3'b001};
    tbl[1]  = '{2,  3'b000};
    tbl[2]  = '{3,  3'b001};
    tbl[3]  = '{4,  3'b010};
    tbl[4]  = '{5,  3'b111};
    tbl[5]  = '{6,  3'b110};
    tbl[6]  = '{7,  3'b101};
    tbl[7]  = '{8,  3'b100};
    tbl[8]  = '{9,  3'b101};
    tbl[9]  = '{10, 3'b000};
    tbl[10] = '{11, 3'b011};
    tbl[11] = '{15, 3'b101};

    rst = 1'b1;
    #1;
    applyStimulus(1'b0, 3);
    checkOutput("reset_state", {o10, o7, o2}, 3'b000);
    checkOutput("reset_state_dflt", {2'b00, oDflt}, 3'b000);

    rst = 1'b1;
    cur = 0;
    foreach (tbl[i]) begin
      repeat (tbl[i].edgeNum - cur) @(negedge clock);
      cur = tbl[i].edgeNum;
      checkOutput($sformatf("vec_edge%0d", cur), {o10, o7, o2}, tbl[i].exp);
    end

    for (int k = 0; k < 150; k++) begin
      @(posedge clock);
      cur++;
      sbQ.push_back(modelAll(cur));
      @(negedge clock);
      checkOutput($sformatf("sb_edge%0d", cur), {o10, o7, o2}, sbQ.pop_front());
    end

    checkOutput("dflt_still_low", {2'b00, oDflt}, 3'b000);

    while ((cur % 10) != 6) begin
      @(negedge clock);
      cur++;
    end
    checkOutput("div10_high_before_rst", {2'b00, o10}, 3'b001);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_reset_immediate", {o10, o7, o2}, 3'b000);
    applyStimulus(1'b0, 3);
    checkOutput("held_in_reset", {o10, o7, o2}, 3'b000);
    checkOutput("held_in_reset_dflt", {2'b00, oDflt}, 3'b000);

    rst = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      checkOutput($sformatf("div10_relaunch%0d", k), {2'b00, o10},
                  (k == 5) ? 3'b001 : 3'b000);
      checkOutput($sformatf("all_relaunch%0d", k), {o10, o7, o2}, modelAll(k));
    end

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
